// File: rtl/output_arbiter_if.sv
`default_nettype none
// ============================================================================
// output_arbiter_if : request/grant bundle between input-port FSMs and one
//                     output-port arbiter.          Revision 1.0
// ============================================================================
interface output_arbiter_if #(
   parameter int NPORT   = 5,
   parameter int PORTIDW = 3
);
   logic [NPORT-1:0]   arb_request_i;
   logic [NPORT-1:0]   arb_stb_i;
   logic               arb_pack_i;
   logic               arb_cancel_i;
   logic [NPORT-1:0]   arb_grant_o;
   logic [NPORT-1:0]   arb_deny_o;
   logic [PORTIDW-1:0] arb_sel_o;
   logic               arb_sel_valid_o;
   logic               arb_busy_o;

   modport slave (
      input  arb_request_i, arb_stb_i, arb_pack_i, arb_cancel_i,
      output arb_grant_o, arb_deny_o, arb_sel_o, arb_sel_valid_o, arb_busy_o
   );

   modport master (
      output arb_request_i, arb_stb_i, arb_pack_i, arb_cancel_i,
      input  arb_grant_o, arb_deny_o, arb_sel_o, arb_sel_valid_o, arb_busy_o
   );
endinterface
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
// output_arbiter : round-robin circuit arbiter for one router output port.
//                  Revision 1.0
// ============================================================================
module output_arbiter #(
   parameter int NPORT   = 5,
   parameter int PORTIDW = 3,
   parameter int TIMEOUT = 16,
   parameter int CNTW    = 5
) (
   input  wire logic       clk,
   input  wire logic       reset,
   output_arbiter_if.slave arb
);
   localparam logic [PORTIDW-1:0] c_last_port = PORTIDW'(NPORT - 1);
   localparam logic [PORTIDW:0]   c_nport     = (PORTIDW + 1)'(NPORT);
   localparam logic [CNTW-1:0]    c_cnt_last  = CNTW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_PACK = 2'd1,
      ST_LOCK      = 2'd2
   } state_t;

   state_t             r_state;
   logic [PORTIDW-1:0] r_ptr;
   logic [PORTIDW-1:0] r_owner;
   logic [CNTW-1:0]    r_cnt;
   logic [NPORT-1:0]   r_denied;
   logic [NPORT-1:0]   r_grant;
   logic [NPORT-1:0]   r_deny;
   logic               r_sel_valid;
   logic               r_busy;

   logic [NPORT-1:0]   w_elig;
   logic [NPORT-1:0]   w_owner_oh;
   logic [NPORT-1:0]   w_win_oh;
   logic [NPORT-1:0]   w_deny_nxt;
   logic [2*NPORT-1:0] w_rot;
   logic [PORTIDW-1:0] w_off;
   logic [PORTIDW-1:0] w_winner;
   logic [PORTIDW-1:0] w_ptr_nxt;
   logic [PORTIDW:0]   w_sum;
   logic               w_found;
   logic               w_owner_stb;

   assign w_elig      = arb.arb_request_i & arb.arb_stb_i & ~r_denied;
   assign w_owner_oh  = NPORT'(1) << r_owner;
   assign w_owner_stb = |(arb.arb_stb_i & w_owner_oh);

   // Rotate eligibility so bit 0 sits at the pointer; lowest set bit is the offset.
   always_comb begin
      w_rot   = {w_elig, w_elig} >> r_ptr;
      w_found = |w_elig;
      w_off   = '0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = PORTIDW'(k);
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= c_nport) w_sum = w_sum - c_nport;
      w_winner  = w_sum[PORTIDW-1:0];
      w_ptr_nxt = (w_winner == c_last_port) ? '0 : w_winner + PORTIDW'(1);
      w_win_oh  = NPORT'(1) << w_winner;
   end

   always_comb begin
      w_deny_nxt = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) w_deny_nxt = w_elig & ~w_win_oh;
         end
         ST_WAIT_PACK: begin
            w_deny_nxt = w_elig & ~w_owner_oh;
            if (w_owner_stb &&
                (arb.arb_cancel_i || (!arb.arb_pack_i && r_cnt == c_cnt_last)))
               w_deny_nxt = w_deny_nxt | w_owner_oh;
         end
         ST_LOCK: begin
            w_deny_nxt = w_elig & ~w_owner_oh;
         end
         default: begin
            w_deny_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_cnt       <= '0;
         r_denied    <= '0;
         r_grant     <= '0;
         r_deny      <= '0;
         r_sel_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_grant  <= '0;
         r_deny   <= w_deny_nxt;
         // A deny sticks until that input drops its strobe.
         r_denied <= (r_denied | w_deny_nxt) & arb.arb_stb_i;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state     <= ST_WAIT_PACK;
                  r_owner     <= w_winner;
                  r_ptr       <= w_ptr_nxt;
                  r_cnt       <= '0;
                  r_grant     <= w_win_oh;
                  r_sel_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_WAIT_PACK: begin
               if (!w_owner_stb || arb.arb_cancel_i) begin
                  r_state     <= ST_IDLE;
                  r_sel_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (arb.arb_pack_i) begin
                  r_state <= ST_LOCK;
               end else if (r_cnt == c_cnt_last) begin
                  r_state     <= ST_IDLE;
                  r_sel_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            ST_LOCK: begin
               if (!w_owner_stb || arb.arb_cancel_i) begin
                  r_state     <= ST_IDLE;
                  r_sel_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_sel_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign arb.arb_grant_o     = r_grant;
   assign arb.arb_deny_o      = r_deny;
   assign arb.arb_sel_o       = r_owner;
   assign arb.arb_sel_valid_o = r_sel_valid;
   assign arb.arb_busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ============================================================================
// tb_output_arbiter : vector table, scripted corners and random traffic
//                     against a cycle-level behavioural model. Revision 1.0
// ============================================================================
module tb_output_arbiter;
   localparam int NPORT   = 5;
   localparam int PORTIDW = 3;
   localparam int TIMEOUT = 4;
   localparam int CNTW    = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   output_arbiter_if #(.NPORT(NPORT), .PORTIDW(PORTIDW)) arb_if ();

   output_arbiter #(
      .NPORT  (NPORT),
      .PORTIDW(PORTIDW),
      .TIMEOUT(TIMEOUT),
      .CNTW   (CNTW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .arb  (arb_if)
   );

   typedef struct {
      bit                 rstn;
      logic [NPORT-1:0]   req;
      logic [NPORT-1:0]   stb;
      bit                 pack;
      bit                 cancel;
      logic [NPORT-1:0]   grant;
      logic [NPORT-1:0]   deny;
      logic [PORTIDW-1:0] sel;
      bit                 sv;
      bit                 busy;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Behavioural model: mode 0 idle, 1 awaiting ack, 2 locked.
   int               m_mode = 0;
   int               m_owner = 0;
   int               m_ptr = 0;
   int               m_deadline = 0;
   int               cyc = 0;
   bit               m_denied[NPORT];
   logic [NPORT-1:0] e_grant = '0;
   logic [NPORT-1:0] e_deny = '0;

   function automatic vec_t mk(bit rstn, logic [NPORT-1:0] req, logic [NPORT-1:0] stb,
                               bit pack, bit cancel, logic [NPORT-1:0] grant,
                               logic [NPORT-1:0] deny, logic [PORTIDW-1:0] sel,
                               bit sv, bit busy);
      vec_t v;
      v.rstn = rstn; v.req = req; v.stb = stb; v.pack = pack; v.cancel = cancel;
      v.grant = grant; v.deny = deny; v.sel = sel; v.sv = sv; v.busy = busy;
      return v;
   endfunction

   task automatic model_update();
      logic [NPORT-1:0] rq;
      logic [NPORT-1:0] sb;
      bit               elig[NPORT];
      int               win;
      rq = arb_if.arb_request_i;
      sb = arb_if.arb_stb_i;
      e_grant = '0;
      e_deny  = '0;
      if (!reset) begin
         m_mode = 0; m_owner = 0; m_ptr = 0;
         for (int i = 0; i < NPORT; i++) m_denied[i] = 1'b0;
      end else begin
         for (int i = 0; i < NPORT; i++) elig[i] = rq[i] && sb[i] && !m_denied[i];
         if (m_mode == 0) begin
            win = -1;
            for (int k = 0; k < NPORT; k++)
               if (win < 0 && elig[(m_ptr + k) % NPORT]) win = (m_ptr + k) % NPORT;
            if (win >= 0) begin
               m_owner = win;
               m_ptr = (win + 1) % NPORT;
               m_mode = 1;
               m_deadline = cyc + TIMEOUT;
               e_grant[win] = 1'b1;
               for (int i = 0; i < NPORT; i++) if (elig[i] && i != win) e_deny[i] = 1'b1;
            end
         end else begin
            for (int i = 0; i < NPORT; i++) if (elig[i] && i != m_owner) e_deny[i] = 1'b1;
            if (!sb[m_owner]) m_mode = 0;
            else if (m_mode == 1) begin
               if (arb_if.arb_cancel_i) begin m_mode = 0; e_deny[m_owner] = 1'b1; end
               else if (arb_if.arb_pack_i) m_mode = 2;
               else if (cyc == m_deadline) begin m_mode = 0; e_deny[m_owner] = 1'b1; end
            end else if (arb_if.arb_cancel_i) m_mode = 0;
         end
         for (int i = 0; i < NPORT; i++) begin
            if (e_deny[i]) m_denied[i] = 1'b1;
            if (!sb[i]) m_denied[i] = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check(string name, logic [NPORT-1:0] g, logic [NPORT-1:0] d,
                        logic [PORTIDW-1:0] s, logic sv, logic b);
      n_vec++;
      if (arb_if.arb_grant_o !== g || arb_if.arb_deny_o !== d || arb_if.arb_sel_o !== s ||
          arb_if.arb_sel_valid_o !== sv || arb_if.arb_busy_o !== b) begin
         n_err++;
         $display("FAIL %s: got grant=%b deny=%b sel=%0d sv=%b busy=%b, want grant=%b deny=%b sel=%0d sv=%b busy=%b",
                  name, arb_if.arb_grant_o, arb_if.arb_deny_o, arb_if.arb_sel_o,
                  arb_if.arb_sel_valid_o, arb_if.arb_busy_o, g, d, s, sv, b);
      end
   endtask

   task automatic check_model(string name);
      check(name, e_grant, e_deny, PORTIDW'(m_owner), m_mode != 0, m_mode != 0);
   endtask

   task automatic drive(logic [NPORT-1:0] req, logic [NPORT-1:0] stb, bit pack, bit cancel);
      arb_if.arb_request_i = req;
      arb_if.arb_stb_i     = stb;
      arb_if.arb_pack_i    = pack;
      arb_if.arb_cancel_i  = cancel;
   endtask

   initial begin
      logic [NPORT-1:0] rs;
      logic [NPORT-1:0] ss;
      int               waited;
      bit               seen;

      reset = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      ss = '0;

      // rstn, req, stb, pack, cancel | grant, deny, sel, sel_valid, busy
      tbl.push_back(mk(0, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 0, 0, 5'b00100, 5'b00000, 2, 1, 1));
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 0, 0, 5'b00000, 5'b00000, 2, 1, 1));
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 1, 0, 5'b00000, 5'b00000, 2, 1, 1));
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 0, 0, 5'b00000, 5'b00000, 2, 1, 1));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0, 0));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00010, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00010, 1, 0, 0));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 0, 0));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 0, 0));
      tbl.push_back(mk(1, 5'b11010, 5'b11010, 0, 0, 5'b01000, 5'b10010, 3, 1, 1));
      tbl.push_back(mk(1, 5'b11010, 5'b11010, 0, 0, 5'b00000, 5'b00000, 3, 1, 1));
      tbl.push_back(mk(1, 5'b11010, 5'b11010, 1, 0, 5'b00000, 5'b00000, 3, 1, 1));
      tbl.push_back(mk(1, 5'b10010, 5'b10010, 0, 0, 5'b00000, 5'b00000, 3, 0, 0));
      tbl.push_back(mk(1, 5'b10010, 5'b00000, 0, 0, 5'b00000, 5'b00000, 3, 0, 0));
      tbl.push_back(mk(1, 5'b10010, 5'b10010, 0, 0, 5'b10000, 5'b00010, 4, 1, 1));
      tbl.push_back(mk(1, 5'b10000, 5'b10000, 0, 1, 5'b00000, 5'b10000, 4, 0, 0));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 4, 0, 0));
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 0, 0, 5'b00001, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 1, 0, 5'b00000, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b01001, 5'b01001, 0, 0, 5'b00000, 5'b01000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b01001, 5'b01001, 0, 0, 5'b00000, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b01001, 5'b01001, 0, 0, 5'b00000, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b01001, 5'b00001, 0, 0, 5'b00000, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b01001, 5'b01001, 0, 0, 5'b00000, 5'b01000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 0, 1, 5'b00000, 5'b00000, 0, 0, 0));
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 0, 0, 5'b00001, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(1, 5'b00001, 5'b00001, 1, 0, 5'b00000, 5'b00000, 0, 1, 1));
      tbl.push_back(mk(0, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 0, 0, 0));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00010, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 0, 0));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00010, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 1, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00010, 5'b00010, 0, 0, 5'b00000, 5'b00000, 1, 1, 1));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 1, 0, 0));
      tbl.push_back(mk(1, 5'b00100, 5'b00100, 0, 0, 5'b00100, 5'b00000, 2, 1, 1));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 1, 5'b00000, 5'b00000, 2, 0, 0));
      tbl.push_back(mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00000, 2, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rstn;
         drive(tbl[i].req, tbl[i].stb, tbl[i].pack, tbl[i].cancel);
         step();
         check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].deny, tbl[i].sel,
               tbl[i].sv, tbl[i].busy);
      end

      // Random traffic with sticky strobes so circuits live for several cycles.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NPORT; i++) begin
            if ($urandom_range(0, 7) == 0) ss[i] = ~ss[i];
            rs[i] = ss[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         end
         reset = ($urandom_range(0, 79) != 0);
         drive(rs, ss, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
         step();
         check_model($sformatf("rand%0d", c));
      end

      // Timeout latency measured with a bounded wait on the owner's deny.
      reset = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      step();
      check_model("seq_reset");
      reset = 1'b1;
      drive(5'b00001, 5'b00001, 1'b0, 1'b0);
      step();
      check_model("seq_grant");
      waited = 0;
      seen = 1'b0;
      while (!seen && waited < 20) begin
         step();
         waited++;
         if (arb_if.arb_deny_o[0] === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen || waited != TIMEOUT || arb_if.arb_sel_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_latency: deny after %0d cycles seen=%0b sv=%b, want %0d cycles sv=0",
                  waited, seen, arb_if.arb_sel_valid_o, TIMEOUT);
      end
      drive('0, '0, 1'b0, 1'b0);
      step();
      check_model("seq_release");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
